// File: rtl/opl2_host_if.sv
// Host-side register write front end for the OPL2 core.
// Decodes host address/data port writes, queues data writes in a small FIFO and
// issues them as one-cycle register write pulses spaced by the OPL2 write timing.
// Host status reads return the timers status byte.
module opl2_host_if #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned ADDR_WAIT_CYCLES = 12,
    parameter int unsigned DATA_WAIT_CYCLES = 84
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic                  wr_n,
    input  logic                  rd_n,
    input  logic                  a0,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic [DATA_WIDTH-1:0] status_in,
    output logic                  reg_wr_valid,
    output logic [DATA_WIDTH-1:0] reg_wr_address,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  busy,
    output logic                  fifo_overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GAP_W = $clog2(DATA_WAIT_CYCLES) + 1;
    localparam int unsigned AW_W  = $clog2(ADDR_WAIT_CYCLES) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Registers and their next-state values
    state_e                state_q,     state_d;
    logic [GAP_W-1:0]      gap_cnt_q,   gap_cnt_d;
    logic [AW_W-1:0]       addr_wait_q, addr_wait_d;
    logic [DATA_WIDTH-1:0] latch_q,     latch_d;
    logic                  wr_act_q,    wr_act_d;
    logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic [DATA_WIDTH-1:0] dout_q,      dout_d;
    logic                  valid_q,     valid_d;
    logic [DATA_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  busy_q,      busy_d;
    logic                  ovf_q,       ovf_d;

    entry_t                fifo_q [FIFO_DEPTH];

    // Decoded strobes for this cycle
    logic   wr_act_c;
    logic   wr_evt_c;
    logic   rd_act_c;
    logic   pop_c;
    logic   full_c;
    logic   push_req_c;
    logic   push_ok_c;
    entry_t push_entry_c;

    // Host strobe decode, FIFO handshake and drain FSM next-state logic
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        addr_wait_d = addr_wait_q;
        latch_d     = latch_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;

        wr_act_c     = !cs_n && !wr_n;
        wr_evt_c     = wr_act_c && !wr_act_q;
        rd_act_c     = !cs_n && !rd_n && wr_n;
        wr_act_d     = wr_act_c;
        full_c       = (count_q == CNT_W'(FIFO_DEPTH));
        pop_c        = (state_q == ST_IDLE) && (count_q != '0);
        push_req_c   = wr_evt_c && a0;
        // A full FIFO still accepts a push when an entry leaves in the same cycle
        push_ok_c    = push_req_c && (!full_c || pop_c);
        push_entry_c = '{addr: latch_q, data: din};

        // Address latch and its busy hold-off
        if (wr_evt_c && !a0) begin
            latch_d     = din;
            addr_wait_d = AW_W'(ADDR_WAIT_CYCLES);
        end else if (addr_wait_q != '0) begin
            addr_wait_d = addr_wait_q - AW_W'(1);
        end

        if (push_req_c && !push_ok_c) begin
            ovf_d = 1'b1;
        end
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);

        // Drain FSM: issue one entry, then wait out the write spacing
        case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    valid_d    = 1'b1;
                    out_addr_d = fifo_q[rd_ptr_q].addr;
                    out_data_d = fifo_q[rd_ptr_q].data;
                    gap_cnt_d  = GAP_W'(DATA_WAIT_CYCLES - 1);
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (count_q != '0) || (state_q != ST_IDLE) || (addr_wait_q != '0);

        // Status read; a concurrent write strobe wins
        if (rd_act_c) begin
            dout_d = a0 ? '1 : status_in;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            addr_wait_q <= '0;
            latch_q     <= '0;
            wr_act_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            addr_wait_q <= addr_wait_d;
            latch_q     <= latch_d;
            wr_act_q    <= wr_act_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; a reset flush only needs the pointers and count
    always_ff @(posedge clk) begin
        if (!reset && push_ok_c) begin
            fifo_q[wr_ptr_q] <= push_entry_c;
        end
    end

    assign dout           = dout_q;
    assign reg_wr_valid   = valid_q;
    assign reg_wr_address = out_addr_q;
    assign reg_wr_data    = out_data_q;
    assign busy           = busy_q;
    assign fifo_overflow  = ovf_q;

endmodule
